// File: rtl/adc_sample_packer.sv
// Saturates 32-bit signed ADC samples to 16 bits, packs pairs into 32-bit words
// and buffers them in a show-ahead FIFO with a valid/ready output and statistics.
module adc_sample_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STAT_W     = 16
) (
    input  logic                        clk_adc,
    input  logic                        rst,
    input  logic [31:0]                 in_sample,
    input  logic                        in_valid,
    input  logic                        in_overflow,
    output logic [31:0]                 out_data,
    output logic                        out_ovr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [STAT_W-1:0]           sat_count,
    output logic [STAT_W-1:0]           drop_count,
    input  logic                        clear_stats
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 2 * HALF_W + 1;

    // Stage 1: saturated sample register
    logic              s1_valid_q, s1_valid_d;
    logic [HALF_W-1:0] s1_data_q, s1_data_d;
    logic              s1_ovr_q, s1_ovr_d;
    logic              sat_hi, sat_lo, clamp;
    logic [HALF_W-1:0] sample_sat;

    // Stage 2: pairing state
    logic              half_q, half_d;
    logic [HALF_W-1:0] low_q, low_d;
    logic              low_ovr_q, low_ovr_d;
    logic              push;
    logic [WORD_W-1:0] push_word;

    // FIFO state
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full, pop, push_acc, drop;
    logic [WORD_W-1:0] head_d;

    // Registered outputs
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_ovr_q, out_ovr_d;
    logic [STAT_W-1:0] sat_count_q, sat_count_d;
    logic [STAT_W-1:0] drop_count_q, drop_count_d;

    always_comb begin
        sat_hi     = $signed(in_sample) > 32'sd32767;
        sat_lo     = $signed(in_sample) < -32'sd32768;
        sample_sat = in_sample[HALF_W-1:0];
        if (sat_hi) begin
            sample_sat = 16'h7FFF;
        end else if (sat_lo) begin
            sample_sat = 16'h8000;
        end
        clamp      = in_valid & (sat_hi | sat_lo);
        s1_valid_d = in_valid;
        s1_data_d  = in_valid ? sample_sat : s1_data_q;
        s1_ovr_d   = in_valid ? in_overflow : s1_ovr_q;
    end

    always_comb begin
        half_d    = half_q ^ s1_valid_q;
        low_d     = low_q;
        low_ovr_d = low_ovr_q;
        if (s1_valid_q && !half_q) begin
            low_d     = s1_data_q;
            low_ovr_d = s1_ovr_q;
        end
        push      = s1_valid_q & half_q;
        push_word = {s1_ovr_q | low_ovr_q, s1_data_q, low_q};
    end

    // A full FIFO still accepts a push when the head is popped on the same edge
    always_comb begin
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = out_valid_q & out_ready;
        push_acc = push & (~full | pop);
        drop     = push & full & ~pop;
        wr_ptr_d = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_acc, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Next head word; the word being written this edge bypasses the memory
    always_comb begin
        head_d = '0;
        if (level_d != '0) begin
            if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_word;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        out_valid_d = (level_d != '0);
        out_data_d  = head_d[31:0];
        out_ovr_d   = head_d[WORD_W-1];
    end

    always_comb begin
        sat_count_d  = sat_count_q;
        drop_count_d = drop_count_q;
        if (clear_stats) begin
            sat_count_d  = '0;
            drop_count_d = '0;
        end else begin
            if (clamp && !(&sat_count_q)) begin
                sat_count_d = sat_count_q + STAT_W'(1);
            end
            if (drop && !(&drop_count_q)) begin
                drop_count_d = drop_count_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_ovr_q     <= 1'b0;
            half_q       <= 1'b0;
            low_q        <= '0;
            low_ovr_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovr_q    <= 1'b0;
            sat_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_ovr_q     <= s1_ovr_d;
            half_q       <= half_d;
            low_q        <= low_d;
            low_ovr_q    <= low_ovr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ovr_q    <= out_ovr_d;
            sat_count_q  <= sat_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage array carries no reset; entries are only read once written
    always_ff @(posedge clk_adc) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ovr    = out_ovr_q;
    assign fifo_level = level_q;
    assign sat_count  = sat_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Randomized and directed bench for adc_sample_packer against a queue-based
// reference model of the saturate/pair/buffer behaviour.
module tb_adc_sample_packer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SMAX  = 65535;

    logic        clk_adc = 1'b0;
    logic        rst;
    logic [31:0] in_sample;
    logic        in_valid;
    logic        in_overflow;
    logic [31:0] out_data;
    logic        out_ovr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_level;
    logic [15:0] sat_count;
    logic [15:0] drop_count;
    logic        clear_stats;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [32:0] m_q[$];
    logic        m_have_low;
    logic [15:0] m_low;
    logic        m_low_ovr;
    logic        m_s1_v;
    logic [15:0] m_s1_d;
    logic        m_s1_o;
    int          m_sat;
    int          m_drop;

    adc_sample_packer #(.FIFO_DEPTH(DEPTH), .STAT_W(16)) dut (
        .clk_adc    (clk_adc),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_overflow(in_overflow),
        .out_data   (out_data),
        .out_ovr    (out_ovr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .sat_count  (sat_count),
        .drop_count (drop_count),
        .clear_stats(clear_stats)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [31:0] s, output logic clamped);
        int v;
        v = $signed(s);
        clamped = 1'b1;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        clamped = 1'b0;
        return s[15:0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_have_low = 1'b0;
        m_low = '0;
        m_low_ovr = 1'b0;
        m_s1_v = 1'b0;
        m_s1_d = '0;
        m_s1_o = 1'b0;
        m_sat = 0;
        m_drop = 0;
    endtask

    task automatic check_all();
        logic [32:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 33'd0;
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("out_data", 64'(out_data), 64'(head[31:0]));
        chk("out_ovr", 64'(out_ovr), 64'(head[32]));
        chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        chk("sat_count", 64'(sat_count), 64'(m_sat));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    // One clock: predict the effect of the current inputs, clock, then compare
    task automatic tick();
        logic        pop, do_push, do_drop, clamped;
        logic [15:0] s;
        logic [32:0] w;
        pop = (m_q.size() != 0) && out_ready;
        do_push = 1'b0;
        do_drop = 1'b0;
        w = '0;
        if (m_s1_v) begin
            if (!m_have_low) begin
                m_low = m_s1_d;
                m_low_ovr = m_s1_o;
                m_have_low = 1'b1;
            end else begin
                w = {m_s1_o | m_low_ovr, m_s1_d, m_low};
                m_have_low = 1'b0;
                if (m_q.size() == DEPTH && !pop) do_drop = 1'b1;
                else do_push = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(w);
        s = sat16(in_sample, clamped);
        if (clear_stats) begin
            m_sat = 0;
            m_drop = 0;
        end else begin
            if (in_valid && clamped && m_sat < SMAX) m_sat++;
            if (do_drop && m_drop < SMAX) m_drop++;
        end
        m_s1_v = in_valid;
        if (in_valid) begin
            m_s1_d = s;
            m_s1_o = in_overflow;
        end
        @(posedge clk_adc);
        #1;
        check_all();
    endtask

    task automatic feed(input logic [31:0] s, input logic ov);
        in_valid = 1'b1;
        in_sample = s;
        in_overflow = ov;
        tick();
        in_valid = 1'b0;
        in_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        in_overflow = 1'b0;
        out_ready = 1'b0;
        clear_stats = 1'b0;
        model_reset();
        @(posedge clk_adc);
        @(posedge clk_adc);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        do_reset();

        // Basic pairing and latency
        out_ready = 1'b1;
        feed(32'd100, 1'b0);
        feed(-32'sd200, 1'b0);
        chk("t1_valid_early", 64'(out_valid), 64'd0);
        idle(1);
        chk("t1_data", 64'(out_data), 64'h0000_0000_FF38_0064);
        chk("t1_valid", 64'(out_valid), 64'd1);
        idle(1);
        chk("t1_valid_after", 64'(out_valid), 64'd0);

        // Saturation both directions and clear
        feed(32'h0001_0000, 1'b0);
        feed(32'hFFFF_0000, 1'b0);
        out_ready = 1'b0;
        idle(1);
        chk("t2_data", 64'(out_data), 64'h0000_0000_8000_7FFF);
        chk("t2_sat", 64'(sat_count), 64'd2);
        clear_stats = 1'b1;
        feed(32'h7FFF_FFFF, 1'b0);
        clear_stats = 1'b0;
        chk("t2_clear", 64'(sat_count), 64'd0);
        out_ready = 1'b1;
        idle(3);

        // Overfill with ramp, then drain in order
        do_reset();
        for (int i = 0; i < 36; i++) feed(32'(i), 1'b0);
        idle(2);
        chk("t3_level", 64'(fifo_level), 64'd16);
        chk("t3_drop", 64'(drop_count), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", 64'(out_data), 64'({16'(2 * i + 1), 16'(2 * i)}));
            tick();
        end
        chk("t3_empty", 64'(out_valid), 64'd0);

        // Push coinciding with pop while full
        do_reset();
        for (int i = 0; i < 32; i++) feed(32'(i), 1'b0);
        feed(32'd1000, 1'b0);
        feed(32'd1001, 1'b0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("t4_drop", 64'(drop_count), 64'd0);
        chk("t4_level", 64'(fifo_level), 64'd16);
        out_ready = 1'b1;
        idle(15);
        chk("t4_last", 64'(out_data), 64'h0000_0000_03E9_03E8);
        idle(1);
        chk("t4_empty", 64'(out_valid), 64'd0);

        // Overflow flag OR per word
        do_reset();
        for (int i = 0; i < 6; i++) feed(32'(i), i == 2);
        idle(2);
        out_ready = 1'b1;
        chk("t5_ovr0", 64'(out_ovr), 64'd0);
        tick();
        chk("t5_ovr1", 64'(out_ovr), 64'd1);
        tick();
        chk("t5_ovr2", 64'(out_ovr), 64'd0);
        idle(2);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 7; i++) feed(32'(i), 1'b0);
        idle(2);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", 64'(out_valid), 64'd0);
        chk("t6_level_async", 64'(fifo_level), 64'd0);
        model_reset();
        @(posedge clk_adc);
        #1;
        rst = 1'b0;
        feed(32'd7, 1'b0);
        feed(32'd8, 1'b0);
        k = 0;
        while (!out_valid && k < 10) begin
            idle(1);
            k++;
        end
        chk("t6_timeout", 64'(k < 10), 64'd1);
        chk("t6_first", 64'(out_data), 64'h0000_0000_0008_0007);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) in_sample = $urandom;
            else in_sample = 32'(int'($urandom_range(0, 70000)) - 35000);
            in_overflow = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) == 0) ^ (i >= 1200);
            clear_stats = ($urandom_range(0, 99) == 0);
            tick();
        end
        in_valid = 1'b0;
        clear_stats = 1'b0;
        out_ready = 1'b1;
        idle(20);
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
